operand_fetch: RTL and testbench

- Register-read stage between decode and execute in the 64-bit integer pipeline.
- Accepts one decoded instruction per cycle and drives the two register-file read ports.
- Bypasses same-cycle writeback data and tracks outstanding destination writes in a 32-entry scoreboard, stalling RAW/WAW hazards.
- Presents registered operands to execute over a valid/ready handshake.

---
 rtl/core_pkg.sv | 25 ++
 rtl/scoreboard.sv | 37 +++
 rtl/operand_fetch.sv | 97 +++++++++
 tb/tb_operand_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared widths, register/bundle types and the operand select rule
package core_pkg;
    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CTRL_W     = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    typedef struct packed {
        xlen_t             pc;
        xlen_t             imm;
        logic [CTRL_W-1:0] ctrl;
        reg_addr_t         rd;
        logic              rd_we;
    } ex_bundle_t;

    // The register file returns pre-write data, so a same-cycle writeback must be forwarded
    function automatic xlen_t sel_operand(input reg_addr_t rs, input logic wb_we,
                                          input reg_addr_t wb_addr, input xlen_t wb_data,
                                          input xlen_t rf_data);
        return (rs == '0) ? '0 : (wb_we && wb_addr == rs) ? wb_data : rf_data;
    endfunction
endpackage

// File: rtl/scoreboard.sv
// scoreboard: pending-write bits per register with set-over-clear priority and hazard lookups
module scoreboard
    import core_pkg::*;
#(
    parameter int NLK = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           set_en,
    input  reg_addr_t      set_addr,
    input  logic           clr_en,
    input  reg_addr_t      clr_addr,
    input  logic           fl_en,
    input  reg_addr_t      fl_addr,
    input  reg_addr_t      lk_addr [NLK],
    output logic [NLK-1:0] lk_hit
);
    logic [NREG-1:0] pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr_en) pend_d[clr_addr] = 1'b0;
        if (fl_en) pend_d[fl_addr] = 1'b0;
        if (set_en) pend_d[set_addr] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend_q <= '0;
        else pend_q <= pend_d;
    end

    // A write retiring this cycle no longer blocks a reader; the bypass supplies its data
    for (genvar i = 0; i < NLK; i++) begin : g_lk
        assign lk_hit[i] = pend_q[lk_addr[i]] && !(clr_en && clr_addr == lk_addr[i]);
    end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage with writeback bypass, scoreboard stalls and a registered
// valid/ready output to execute
module operand_fetch
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  reg_addr_t         id_rs1,
    input  reg_addr_t         id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  reg_addr_t         id_rd,
    input  logic              id_rd_we,
    input  xlen_t             id_pc,
    input  xlen_t             id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    output reg_addr_t         rd_addr_0,
    output reg_addr_t         rd_addr_1,
    input  xlen_t             rd_data_0,
    input  xlen_t             rd_data_1,
    input  logic              wb_we,
    input  reg_addr_t         wb_addr,
    input  xlen_t             wb_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output xlen_t             ex_op1,
    output xlen_t             ex_op2,
    output reg_addr_t         ex_rd,
    output logic              ex_rd_we,
    output xlen_t             ex_pc,
    output xlen_t             ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl
);
    logic       raw, waw, issue, wb_clr, fl_clr;
    logic       valid_q, valid_d;
    logic [2:0] lk_hit;
    reg_addr_t  lk_addr [3];
    xlen_t      op1_q, op1_d, op2_q, op2_d;
    ex_bundle_t bundle_q, bundle_d;

    assign rd_addr_0 = id_rs1;
    assign rd_addr_1 = id_rs2;
    assign lk_addr   = '{id_rs1, id_rs2, id_rd};

    scoreboard #(.NLK(3)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue && id_rd_we && id_rd != '0),
        .set_addr (id_rd),
        .clr_en   (wb_clr),
        .clr_addr (wb_addr),
        .fl_en    (fl_clr),
        .fl_addr  (bundle_q.rd),
        .lk_addr  (lk_addr),
        .lk_hit   (lk_hit)
    );

    always_comb begin
        raw      = (id_uses_rs1 && lk_hit[0]) || (id_uses_rs2 && lk_hit[1]);
        waw      = id_rd_we && id_rd != '0 && lk_hit[2];
        id_ready = rst && !flush && !raw && !waw && (!valid_q || ex_ready);
        issue    = id_valid && id_ready;
        wb_clr   = wb_we && wb_addr != '0;
        fl_clr   = flush && valid_q && bundle_q.rd_we && bundle_q.rd != '0;
        valid_d  = issue ? 1'b1 : (flush || ex_ready) ? 1'b0 : valid_q;
        bundle_d = issue ? '{pc: id_pc, imm: id_imm, ctrl: id_ctrl, rd: id_rd, rd_we: id_rd_we}
                         : bundle_q;
        op1_d    = issue ? sel_operand(id_rs1, wb_we, wb_addr, wb_data, rd_data_0) : op1_q;
        op2_d    = issue ? sel_operand(id_rs2, wb_we, wb_addr, wb_data, rd_data_1) : op2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
        end
    end

    assign ex_valid = valid_q;
    assign ex_op1   = op1_q;
    assign ex_op2   = op2_q;
    assign ex_rd    = bundle_q.rd;
    assign ex_rd_we = bundle_q.rd_we;
    assign ex_pc    = bundle_q.pc;
    assign ex_imm   = bundle_q.imm;
    assign ex_ctrl  = bundle_q.ctrl;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and random checks of operand_fetch against a pending-set / queue model
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        rst, id_valid, id_uses_rs1, id_uses_rs2, id_rd_we, wb_we, flush, ex_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_addr;
    logic [63:0] id_pc, id_imm, wb_data;
    logic [15:0] id_ctrl;
    logic        id_ready, ex_valid, ex_rd_we;
    logic [4:0]  rd_addr_0, rd_addr_1, ex_rd;
    logic [63:0] rd_data_0, rd_data_1, ex_op1, ex_op2, ex_pc, ex_imm;
    logic [15:0] ex_ctrl;

    int          vec = 0, err = 0;
    logic [63:0] rf [32];
    logic [31:0] pend;
    logic [278:0] m_vec;
    wire  [278:0] dut_vec = {ex_valid, ex_op1, ex_op2, ex_rd, ex_rd_we, ex_pc, ex_imm, ex_ctrl};

    always #5 clk = ~clk;
    assign rd_data_0 = rf[rd_addr_0];
    assign rd_data_1 = rf[rd_addr_1];

    operand_fetch dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_pc(id_pc), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1), .rd_data_0(rd_data_0), .rd_data_1(rd_data_1),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
    );

    function automatic logic blocked(input logic [4:0] r);
        return r != 0 && pend[r] && !(wb_we && wb_addr == r);
    endfunction

    function automatic logic m_ready();
        logic hz;
        hz = (id_uses_rs1 && blocked(id_rs1)) || (id_uses_rs2 && blocked(id_rs2)) ||
             (id_rd_we && blocked(id_rd));
        return rst && !flush && !hz && (!m_vec[278] || ex_ready);
    endfunction

    function automatic logic [63:0] m_op(input logic [4:0] rs);
        if (rs == 0) return 64'd0;
        if (wb_we && wb_addr == rs) return wb_data;
        return rf[rs];
    endfunction

    task automatic tick();
        logic iss;
        logic [278:0] nxt;
        iss = id_valid && m_ready();
        nxt = m_vec;
        if (iss) nxt = {1'b1, m_op(id_rs1), m_op(id_rs2), id_rd, id_rd_we, id_pc, id_imm, id_ctrl};
        else if (flush || ex_ready) nxt[278] = 1'b0;
        @(posedge clk);
        if (!rst) begin
            pend  = '0;
            m_vec = '0;
        end else begin
            if (wb_we && wb_addr != 0) pend[wb_addr] = 1'b0;
            if (flush && m_vec[278] && m_vec[144] && m_vec[149:145] != 0) pend[m_vec[149:145]] = 1'b0;
            if (iss && id_rd_we && id_rd != 0) pend[id_rd] = 1'b1;
            m_vec = nxt;
            if (wb_we) rf[wb_addr] = wb_data;
        end
        #1;
    endtask

    task automatic instr(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                         input logic u2, input logic [4:0] rd, input logic we);
        id_valid = v; id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
        id_rd = rd; id_rd_we = we;
        id_pc = {$urandom, $urandom}; id_imm = {$urandom, $urandom}; id_ctrl = 16'($urandom);
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [63:0] d);
        wb_we = we; wb_addr = a; wb_data = d;
    endtask

    task automatic test_reset(input logic [4:0] r);
        rst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
        wb(1'b0, 5'd0, 64'd0);
        #1; pend = '0; m_vec = '0;
        @(negedge clk);
        vec++; if (id_ready !== 1'b0) begin err++; $display("FAIL reset_ready: got %b want 0", id_ready); end
        vec++; if (dut_vec !== '0) begin err++; $display("FAIL reset_out: got %h want 0", dut_vec); end
        tick();
        vec++; if (ex_valid !== 1'b0) begin err++; $display("FAIL reset_hold_valid: got %b want 0", ex_valid); end
        @(negedge clk); rst = 1'b1;
        instr(1'b1, r, 1'b1, r, 1'b1, r, 1'b1);
        #1;
        vec++; if (id_ready !== 1'b1) begin err++; $display("FAIL reset_release_ready: got %b want 1", id_ready); end
        tick();
        vec++; if (ex_valid !== 1'b1) begin err++; $display("FAIL reset_first_issue: got %b want 1", ex_valid); end
        vec++; if (dut_vec !== m_vec) begin err++; $display("FAIL reset_first_out: got %h want %h", dut_vec, m_vec); end
        wb(1'b1, r, 64'd0);
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        wb(1'b0, 5'd0, 64'd0);
    endtask

    task automatic test_basic_read();
        rf[5] = 64'h1234; ex_ready = 1'b1;
        instr(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        vec++; if (id_ready !== 1'b1) begin err++; $display("FAIL basic_ready: got %b want 1", id_ready); end
        vec++; if ({rd_addr_0, rd_addr_1} !== {5'd5, 5'd0}) begin err++; $display("FAIL basic_rd_addr: got %0d/%0d want 5/0", rd_addr_0, rd_addr_1); end
        tick();
        vec++; if ({ex_valid, ex_op1, ex_op2} !== {1'b1, 64'h1234, 64'd0}) begin err++; $display("FAIL basic_ops: got %b %h %h want 1 1234 0", ex_valid, ex_op1, ex_op2); end
        vec++; if (dut_vec !== m_vec) begin err++; $display("FAIL basic_out: got %h want %h", dut_vec, m_vec); end
    endtask

    task automatic test_wb_bypass();
        instr(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        wb(1'b1, 5'd7, 64'hDEAD_BEEF);
        @(negedge clk);
        vec++; if (id_ready !== 1'b1) begin err++; $display("FAIL bypass_ready: got %b want 1", id_ready); end
        tick();
        vec++; if (ex_op1 !== 64'hDEAD_BEEF) begin err++; $display("FAIL bypass_op1: got %h want deadbeef", ex_op1); end
        wb(1'b1, 5'd0, 64'hFFFF);
        instr(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        tick();
        vec++; if (ex_op1 !== 64'd0) begin err++; $display("FAIL bypass_x0: got %h want 0", ex_op1); end
        wb(1'b0, 5'd0, 64'd0);
    endtask

    task automatic test_raw_stall();
        logic [63:0] d;
        d = {$urandom, $urandom};
        instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
        @(negedge clk);
        vec++; if (id_ready !== 1'b1) begin err++; $display("FAIL raw_first_ready: got %b want 1", id_ready); end
        tick();
        instr(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++; if (id_ready !== 1'b0) begin err++; $display("FAIL raw_stall_%0d: got %b want 0", i, id_ready); end
            tick();
        end
        vec++; if (ex_valid !== 1'b0) begin err++; $display("FAIL raw_bubble: got %b want 0", ex_valid); end
        wb(1'b1, 5'd3, d);
        @(negedge clk);
        vec++; if (id_ready !== 1'b1) begin err++; $display("FAIL raw_release: got %b want 1", id_ready); end
        tick();
        vec++; if (ex_op2 !== d) begin err++; $display("FAIL raw_bypass_op2: got %h want %h", ex_op2, d); end
        wb(1'b0, 5'd0, 64'd0);
        instr(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        vec++; if (id_ready !== 1'b1) begin err++; $display("FAIL raw_cleared: got %b want 1", id_ready); end
        tick();
    endtask

    task automatic test_backpressure_waw();
        logic [278:0] snap;
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        tick();
        snap = m_vec;
        ex_ready = 1'b0;
        instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++; if (id_ready !== 1'b0) begin err++; $display("FAIL bp_ready_%0d: got %b want 0", i, id_ready); end
            tick();
            vec++; if (dut_vec !== snap) begin err++; $display("FAIL bp_hold_%0d: got %h want %h", i, dut_vec, snap); end
        end
        ex_ready = 1'b1;
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vec++; if (id_ready !== 1'b0) begin err++; $display("FAIL waw_stall_%0d: got %b want 0", i, id_ready); end
            tick();
        end
        wb(1'b1, 5'd9, {$urandom, $urandom});
        @(negedge clk);
        vec++; if (id_ready !== 1'b1) begin err++; $display("FAIL waw_release: got %b want 1", id_ready); end
        tick();
        vec++; if (dut_vec !== m_vec) begin err++; $display("FAIL waw_out: got %h want %h", dut_vec, m_vec); end
        wb(1'b0, 5'd0, 64'd0);
        instr(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        vec++; if (id_ready !== 1'b0) begin err++; $display("FAIL waw_set_wins: got %b want 0", id_ready); end
        tick();
        wb(1'b1, 5'd9, {$urandom, $urandom});
        tick();
        wb(1'b0, 5'd0, 64'd0);
    endtask

    task automatic test_flush();
        ex_ready = 1'b1;
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        @(negedge clk);
        vec++; if (id_ready !== 1'b1) begin err++; $display("FAIL flush_setup_ready: got %b want 1", id_ready); end
        tick();
        ex_ready = 1'b0; flush = 1'b1;
        instr(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        vec++; if (id_ready !== 1'b0) begin err++; $display("FAIL flush_no_issue: got %b want 0", id_ready); end
        tick();
        vec++; if (ex_valid !== 1'b0) begin err++; $display("FAIL flush_valid: got %b want 0", ex_valid); end
        flush = 1'b0; ex_ready = 1'b1;
        instr(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1);
        @(negedge clk);
        vec++; if (id_ready !== 1'b1) begin err++; $display("FAIL flush_pend_clear: got %b want 1", id_ready); end
        tick();
        ex_ready = 1'b0; flush = 1'b1;
        wb(1'b1, 5'd4, 64'd1);
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        flush = 1'b0; ex_ready = 1'b1;
        wb(1'b0, 5'd0, 64'd0);
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        @(negedge clk);
        vec++; if (id_ready !== 1'b1) begin err++; $display("FAIL flush_wb_same: got %b want 1", id_ready); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            instr(($urandom % 4) != 0, 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
            wb(($urandom % 3) == 0, 5'($urandom_range(0, 7)), {$urandom, $urandom});
            ex_ready = ($urandom % 4) != 0;
            flush = ($urandom % 16) == 0;
            @(negedge clk);
            vec++; if (id_ready !== m_ready()) begin err++; $display("FAIL rand_ready[%0d]: got %b want %b", i, id_ready, m_ready()); end
            tick();
            vec++; if (dut_vec !== m_vec) begin err++; $display("FAIL rand_out[%0d]: got %h want %h", i, dut_vec, m_vec); end
        end
        flush = 1'b0;
    endtask

    initial begin
        logic [4:0] pr;
        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
        rst = 1'b1; pend = '0; m_vec = '0;
        instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        wb(1'b0, 5'd0, 64'd0);
        flush = 1'b0; ex_ready = 1'b1;
        test_reset(5'd5);
        test_basic_read();
        test_wb_bypass();
        test_raw_stall();
        test_backpressure_waw();
        test_flush();
        test_random();
        ex_ready = 1'b1;
        instr(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
        wb(1'b0, 5'd0, 64'd0);
        tick();
        pr = 5'd12;
        for (int i = 31; i > 0; i--) if (pend[i]) pr = 5'(i);
        test_reset(pr);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
